// File: rtl/clusterv_mem_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encoding, default widths
// and the timeout-counter sizing helper.
package clusterv_mem_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int CLUSTERV_MEM_ADR_WIDTH    = 12;
    localparam int CLUSTERV_MEM_DAT_WIDTH    = 32;
    localparam int CLUSTERV_MEM_TMO_CYCLES   = 16;

    // Never returns 0 so a degenerate TIMEOUT_CYCLES still yields a legal vector.
    function automatic int tmo_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    localparam int CLUSTERV_MEM_TMO_WIDTH = tmo_width(CLUSTERV_MEM_TMO_CYCLES);

endpackage

// File: rtl/clusterv_rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the index
// that was not served last.
module clusterv_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       gnt_vld
);

    always_comb begin
        gnt_vld = |req;
        case (req)
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/clusterv_mem_arb_2x1.sv
// Round-robin Wishbone arbiter, two initiators onto one SRAM controller target.
// Optional ack watchdog enabled by defining CLUSTERV_MEM_ARB_TIMEOUT_EN.
module clusterv_mem_arb_2x1
    import clusterv_mem_pkg::*;
#(
    parameter int ADR_WIDTH      = CLUSTERV_MEM_ADR_WIDTH,
    parameter int DAT_WIDTH      = CLUSTERV_MEM_DAT_WIDTH,
    parameter int TIMEOUT_CYCLES = CLUSTERV_MEM_TMO_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADR_WIDTH-1:0]   t0_adr,
    input  logic [DAT_WIDTH-1:0]   t0_dat_w,
    output logic [DAT_WIDTH-1:0]   t0_dat_r,
    input  logic                   t0_cyc,
    input  logic                   t0_stb,
    input  logic                   t0_we,
    input  logic [DAT_WIDTH/8-1:0] t0_sel,
    output logic                   t0_ack,
    output logic                   t0_err,
    input  logic [ADR_WIDTH-1:0]   t1_adr,
    input  logic [DAT_WIDTH-1:0]   t1_dat_w,
    output logic [DAT_WIDTH-1:0]   t1_dat_r,
    input  logic                   t1_cyc,
    input  logic                   t1_stb,
    input  logic                   t1_we,
    input  logic [DAT_WIDTH/8-1:0] t1_sel,
    output logic                   t1_ack,
    output logic                   t1_err,
    output logic [ADR_WIDTH-1:0]   i_adr,
    output logic [DAT_WIDTH-1:0]   i_dat_w,
    output logic                   i_we,
    output logic [DAT_WIDTH/8-1:0] i_sel,
    output logic                   i_cyc,
    output logic                   i_stb,
    input  logic [DAT_WIDTH-1:0]   i_dat_r,
    input  logic                   i_ack,
    input  logic                   i_err,
    output logic                   busy,
    output logic                   owner
);

    localparam int SEL_WIDTH = DAT_WIDTH / 8;

    arb_state_e state_reg, state_next;
    logic       owner_reg, owner_next;
    logic       last_reg, last_next;
    logic       gnt, gnt_vld, tmo_hit, busy_w, done;

    logic [ADR_WIDTH-1:0] t_adr   [2];
    logic [DAT_WIDTH-1:0] t_dat_w [2];
    logic [SEL_WIDTH-1:0] t_sel   [2];
    logic [DAT_WIDTH-1:0] dat_r_vec [2];
    logic [1:0]           t_cyc, t_stb, t_we, req, ack_vec, err_vec;

    assign t_adr   = '{t0_adr, t1_adr};
    assign t_dat_w = '{t0_dat_w, t1_dat_w};
    assign t_sel   = '{t0_sel, t1_sel};
    assign t_cyc   = {t1_cyc, t0_cyc};
    assign t_stb   = {t1_stb, t0_stb};
    assign t_we    = {t1_we, t0_we};

    assign busy_w = (state_reg == ARB_BUSY);

    // Responses reach only the current owner; everyone else reads zeros.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            logic is_owner;
            assign is_owner      = busy_w && (owner_reg == 1'(gi));
            assign req[gi]       = t_cyc[gi] & t_stb[gi];
            assign ack_vec[gi]   = is_owner & i_ack;
            assign err_vec[gi]   = is_owner & (i_err | tmo_hit);
            assign dat_r_vec[gi] = is_owner ? i_dat_r : '0;
        end
    endgenerate

    assign t0_ack   = ack_vec[0];
    assign t1_ack   = ack_vec[1];
    assign t0_err   = err_vec[0];
    assign t1_err   = err_vec[1];
    assign t0_dat_r = dat_r_vec[0];
    assign t1_dat_r = dat_r_vec[1];
    assign busy     = busy_w;
    assign owner    = owner_reg;

    clusterv_rr_arb2 u_rr (
        .req     (req),
        .last    (last_reg),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

`ifdef CLUSTERV_MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = tmo_width(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_reg, tmo_next;

    // An abort in the expiry cycle wins, so no error is raised for a dropped cycle.
    assign tmo_hit = busy_w && t_cyc[owner_reg] && !i_ack && !i_err &&
                     (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_next = tmo_reg;
        if (!busy_w && gnt_vld)
            tmo_next = '0;
        else if (busy_w && !i_ack && !i_err)
            tmo_next = tmo_reg + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            tmo_reg <= '0;
        else
            tmo_reg <= tmo_next;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign done = i_ack | i_err | ~t_cyc[owner_reg] | tmo_hit;

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (gnt_vld) begin
                    state_next = ARB_BUSY;
                    owner_next = gnt;
                end
            end
            ARB_BUSY: begin
                if (done) begin
                    state_next = ARB_IDLE;
                    last_next  = owner_reg;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        i_adr   = '0;
        i_dat_w = '0;
        i_sel   = '0;
        i_we    = 1'b0;
        i_cyc   = 1'b0;
        i_stb   = 1'b0;
        if (busy_w) begin
            i_adr   = t_adr[owner_reg];
            i_dat_w = t_dat_w[owner_reg];
            i_sel   = t_sel[owner_reg];
            i_we    = t_we[owner_reg];
            i_cyc   = t_cyc[owner_reg] & ~tmo_hit;
            i_stb   = t_stb[owner_reg] & ~tmo_hit;
        end
    end

    // last resets to 1 so t0 takes the first tie after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ARB_IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
        end
    end

endmodule

// File: tb/tb_clusterv_mem_arb_2x1.sv
// Directed self-checking bench for clusterv_mem_arb_2x1 (timeout case only when
// CLUSTERV_MEM_ARB_TIMEOUT_EN is defined).
module tb_clusterv_mem_arb_2x1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] t0_adr = '0, t1_adr = '0, i_adr;
    logic [31:0] t0_dat_w = '0, t1_dat_w = '0, t0_dat_r, t1_dat_r, i_dat_w, i_dat_r = '0;
    logic        t0_cyc = 0, t0_stb = 0, t0_we = 0, t1_cyc = 0, t1_stb = 0, t1_we = 0;
    logic [3:0]  t0_sel = '0, t1_sel = '0, i_sel;
    logic        t0_ack, t0_err, t1_ack, t1_err;
    logic        i_we, i_cyc, i_stb, i_ack = 0, i_err = 0, busy, owner;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    clusterv_mem_arb_2x1 dut (
        .clock(clock), .reset(reset),
        .t0_adr(t0_adr), .t0_dat_w(t0_dat_w), .t0_dat_r(t0_dat_r), .t0_cyc(t0_cyc),
        .t0_stb(t0_stb), .t0_we(t0_we), .t0_sel(t0_sel), .t0_ack(t0_ack), .t0_err(t0_err),
        .t1_adr(t1_adr), .t1_dat_w(t1_dat_w), .t1_dat_r(t1_dat_r), .t1_cyc(t1_cyc),
        .t1_stb(t1_stb), .t1_we(t1_we), .t1_sel(t1_sel), .t1_ack(t1_ack), .t1_err(t1_err),
        .i_adr(i_adr), .i_dat_w(i_dat_w), .i_we(i_we), .i_sel(i_sel),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_dat_r(i_dat_r), .i_ack(i_ack), .i_err(i_err),
        .busy(busy), .owner(owner)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        // Reset held with both requesting and memory acking: everything must stay quiet.
        tick(); tick();
        t0_cyc = 1; t0_stb = 1; t1_cyc = 1; t1_stb = 1; t0_adr = 12'h123;
        i_ack = 1; i_dat_r = 32'hDEADBEEF;
        #1;
        chk("rst_i_cyc",   32'(i_cyc),   32'h0);
        chk("rst_i_stb",   32'(i_stb),   32'h0);
        chk("rst_i_adr",   32'(i_adr),   32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_owner",   32'(owner),   32'h0);
        chk("rst_t0_ack",  32'(t0_ack),  32'h0);
        chk("rst_t1_ack",  32'(t1_ack),  32'h0);
        chk("rst_t0_dat_r", t0_dat_r,    32'h0);
        i_ack = 0;
        reset = 1;
        tick();
        chk("rel_busy",  32'(busy),  32'h1);
        chk("rel_owner", 32'(owner), 32'h0);
        chk("rel_i_stb", 32'(i_stb), 32'h1);
        chk("rel_i_adr", 32'(i_adr), 32'h123);
        i_ack = 1; #1;
        chk("rel_t0_ack", 32'(t0_ack), 32'h1);
        chk("rel_t1_ack", 32'(t1_ack), 32'h0);
        tick();
        i_ack = 0; t0_cyc = 0; t0_stb = 0; t1_cyc = 0; t1_stb = 0;
        $display("txn reset-release: t0 granted first");

        // Single read by t0, ack two cycles after i_stb rises.
        t0_adr = 12'h405; t0_we = 0; t0_sel = 4'hF; t0_cyc = 1; t0_stb = 1;
        tick();
        chk("rd_i_adr", 32'(i_adr), 32'h405);
        chk("rd_i_we",  32'(i_we),  32'h0);
        chk("rd_ack_w0", 32'(t0_ack), 32'h0);
        tick();
        chk("rd_ack_w1", 32'(t0_ack), 32'h0);
        tick();
        i_ack = 1; i_dat_r = 32'hCAFEF00D; #1;
        chk("rd_t0_dat_r", t0_dat_r,     32'hCAFEF00D);
        chk("rd_t0_ack",   32'(t0_ack),  32'h1);
        chk("rd_t1_ack",   32'(t1_ack),  32'h0);
        chk("rd_t1_dat_r", t1_dat_r,     32'h0);
        tick();
        i_ack = 0; t0_cyc = 0; t0_stb = 0; #1;
        chk("rd_t0_ack_off", 32'(t0_ack), 32'h0);
        chk("rd_idle",       32'(busy),   32'h0);
        $display("txn t0 read adr=0x405 data=0x%08h", t0_dat_r);

        // Write pass-through from t1.
        t1_adr = 12'hC00; t1_dat_w = 32'h12345678; t1_sel = 4'b0101; t1_we = 1;
        t1_cyc = 1; t1_stb = 1;
        tick();
        chk("wr_owner",   32'(owner),  32'h1);
        chk("wr_i_adr",   32'(i_adr),  32'hC00);
        chk("wr_i_dat_w", i_dat_w,     32'h12345678);
        chk("wr_i_sel",   32'(i_sel),  32'h5);
        chk("wr_i_we",    32'(i_we),   32'h1);
        chk("wr_i_cyc",   32'(i_cyc),  32'h1);
        i_ack = 1; #1;
        chk("wr_t1_ack", 32'(t1_ack), 32'h1);
        chk("wr_t0_ack", 32'(t0_ack), 32'h0);
        tick();
        i_ack = 0; t1_cyc = 0; t1_stb = 0; t1_we = 0;
        $display("txn t1 write adr=0xC00 data=0x12345678 sel=0101");

        // Contention: both request continuously, expect strict alternation from t0.
        t0_cyc = 1; t0_stb = 1; t1_cyc = 1; t1_stb = 1;
        for (int k = 0; k < 8; k++) begin
            logic exp_own;
            exp_own = 1'(k % 2);
            tick();
            chk("ct_owner", 32'(owner), 32'(exp_own));
            chk("ct_busy",  32'(busy),  32'h1);
            i_ack = 1; #1;
            chk("ct_ack_own", 32'(exp_own ? t1_ack : t0_ack), 32'h1);
            chk("ct_ack_oth", 32'(exp_own ? t0_ack : t1_ack), 32'h0);
            tick();
            i_ack = 0;
            if (k == 7) begin
                t0_cyc = 0; t0_stb = 0; t1_cyc = 0; t1_stb = 0;
            end
            #1;
            chk("ct_gap", 32'(busy), 32'h0);
            $display("txn contention %0d granted t%0d", k, exp_own);
        end

        // Abort: t1 owns, t0 waits, t1 drops cyc before any ack.
        t1_adr = 12'h0AA; t1_cyc = 1; t1_stb = 1;
        tick();
        chk("ab_owner", 32'(owner), 32'h1);
        t0_adr = 12'h055; t0_cyc = 1; t0_stb = 1;
        tick();
        chk("ab_hold_busy", 32'(busy),   32'h1);
        chk("ab_hold_adr",  32'(i_adr),  32'h0AA);
        chk("ab_t0_stall",  32'(t0_ack), 32'h0);
        t1_cyc = 0; t1_stb = 0; #1;
        chk("ab_i_cyc", 32'(i_cyc),  32'h0);
        chk("ab_t1_ack", 32'(t1_ack), 32'h0);
        tick();
        chk("ab_idle", 32'(busy), 32'h0);
        tick();
        chk("ab_t0_owner", 32'(owner), 32'h0);
        chk("ab_t0_busy",  32'(busy),  32'h1);
        chk("ab_t0_adr",   32'(i_adr), 32'h055);
        i_ack = 1; #1;
        chk("ab_t0_ack", 32'(t0_ack), 32'h1);
        tick();
        i_ack = 0; t0_cyc = 0; t0_stb = 0;
        $display("txn t1 abort, pending t0 served");

`ifdef CLUSTERV_MEM_ARB_TIMEOUT_EN
        // Never ack: error pulse on the 16th BUSY cycle, then re-arbitration.
        t0_cyc = 1; t0_stb = 1;
        tick();
        for (int c = 1; c < 16; c++) begin
            chk("to_no_err", 32'(t0_err), 32'h0);
            tick();
        end
        chk("to_err",   32'(t0_err), 32'h1);
        chk("to_i_cyc", 32'(i_cyc),  32'h0);
        chk("to_t1_err", 32'(t1_err), 32'h0);
        tick();
        chk("to_idle",    32'(busy),   32'h0);
        chk("to_err_off", 32'(t0_err), 32'h0);
        tick();
        chk("to_regrant", 32'(busy), 32'h1);
        t0_cyc = 0; t0_stb = 0;
        tick();
        $display("txn t0 timeout after 16 busy cycles");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
